psg_stereo_mixer: RTL and testbench

- Parametrised, register-programmable stereo mixer for NUM_CH unsigned PSG channel outputs, for example the A/B/C outputs of several PSG cores.
- On each sample strobe it snapshots all channels and accumulates per-channel left/right gain products, one channel per clock, through a time-multiplexed multiply-accumulate.
- It then applies mute, mono and shift, saturates, and emits a signed stereo sample with a one-cycle valid pulse.
- It sits between the PSG cores and the low-pass/DC filter and I2S path, replacing the fixed single-mono mix.

---
 rtl/psg_stereo_mixer.sv | 177 +++++++++++++++++
 tb/tb_psg_stereo_mixer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_stereo_mixer.sv
// Register-programmable stereo mixer for PSG channel outputs.
// One channel per clock is multiplied by left/right gains and accumulated.
module psg_stereo_mixer #(
  parameter int NUM_CH    = 6,
  parameter int IN_BITS   = 8,
  parameter int GAIN_BITS = 4,
  parameter int OUT_BITS  = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen_in,
  input  logic [NUM_CH*IN_BITS-1:0] ch_in,
  input  logic                      wr,
  input  logic [7:0]                waddr,
  input  logic [7:0]                wdata,
  output logic [OUT_BITS-1:0]       out_left,
  output logic [OUT_BITS-1:0]       out_right,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int CW    = $clog2(NUM_CH + 1);
  localparam int ACC_W = IN_BITS + 1 + GAIN_BITS + CW;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW0   = ACC_W + 1 + OUT_SHIFT;
  localparam int FW    = ((FW0 > OUT_BITS) ? FW0 : OUT_BITS) + 1;

  localparam logic signed [IN_BITS:0] HALF =
    (IN_BITS+1)'(1) << (IN_BITS - 1);
  localparam logic signed [FW-1:0] MAXV =
    {{(FW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [FW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t state, state_nx;

  logic [GAIN_BITS-1:0] gl [NUM_CH];
  logic [GAIN_BITS-1:0] gr [NUM_CH];
  logic [GAIN_BITS-1:0] sgl [NUM_CH];
  logic [GAIN_BITS-1:0] sgr [NUM_CH];
  logic [IN_BITS-1:0]   snap [NUM_CH];
  logic [2:0]           ctrl, sctrl;
  logic [IDX_W-1:0]     idx;
  logic                 last;
  logic                 ctrl_wr;

  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic signed [IN_BITS:0] s_cur;
  logic signed [ACC_W-1:0] s_ext, prod_l, prod_r;
  logic signed [FW-1:0]    sum, mono_v, side_l, side_r, v_l, v_r;
  logic [OUT_BITS-1:0]     y_l, y_r;

  function automatic logic [OUT_BITS-1:0] sat(
    input logic signed [FW-1:0] v
  );
    if (v > MAXV)
      return MAXV[OUT_BITS-1:0];
    else if (v < MINV)
      return MINV[OUT_BITS-1:0];
    else
      return v[OUT_BITS-1:0];
  endfunction

  assign busy    = (state != IDLE);
  assign last    = (idx == IDX_W'(NUM_CH - 1));
  assign ctrl_wr = wr && (waddr == 8'(NUM_CH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        gl[i] <= GAIN_BITS'(4'h8);
        gr[i] <= GAIN_BITS'(4'h8);
      end
      ctrl    <= '0;
      overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && waddr == 8'(i)) begin
          gl[i] <= wdata[GAIN_BITS-1:0];
          gr[i] <= wdata[4 +: GAIN_BITS];
        end
      end
      if (ctrl_wr)
        ctrl <= wdata[2:0];
      // A strobe that lands while busy beats a same-cycle clear.
      if (ctrl_wr && wdata[7])
        overrun <= 1'b0;
      if (cen_in && busy)
        overrun <= 1'b1;
    end
  end

  always_comb begin
    s_cur = $signed({1'b0, snap[idx]});
    if (sctrl[2])
      s_cur = s_cur - HALF;
    s_ext  = ACC_W'(s_cur);
    prod_l = s_ext * $signed(ACC_W'(sgl[idx]));
    prod_r = s_ext * $signed(ACC_W'(sgr[idx]));
  end

  always_comb begin
    sum    = FW'(acc_l) + FW'(acc_r);
    mono_v = sum >>> 1;
    side_l = sctrl[1] ? mono_v : FW'(acc_l);
    side_r = sctrl[1] ? mono_v : FW'(acc_r);
    v_l    = side_l <<< OUT_SHIFT;
    v_r    = side_r <<< OUT_SHIFT;
    y_l    = sctrl[0] ? '0 : sat(v_l);
    y_r    = sctrl[0] ? '0 : sat(v_r);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cen_in) state_nx = ACCUM;
      ACCUM:   if (last) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap[i] <= '0;
        sgl[i]  <= '0;
        sgr[i]  <= '0;
      end
      sctrl     <= '0;
      idx       <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: if (cen_in) begin
          for (int i = 0; i < NUM_CH; i++) begin
            snap[i] <= ch_in[i*IN_BITS +: IN_BITS];
            sgl[i]  <= gl[i];
            sgr[i]  <= gr[i];
          end
          sctrl <= ctrl;
          idx   <= '0;
          acc_l <= '0;
          acc_r <= '0;
        end
        ACCUM: begin
          acc_l <= acc_l + prod_l;
          acc_r <= acc_r + prod_r;
          if (!last)
            idx <= idx + 1'b1;
        end
        OUT: begin
          out_left  <= y_l;
          out_right <= y_r;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Bench for psg_stereo_mixer: scoreboard of expected stereo samples.
// A 12-bit output instance shares the register bus for saturation cases.
module tb_psg_stereo_mixer;

  logic        clk = 1'b0;
  logic        rst, cen_in, cen2, wr;
  logic [47:0] ch_in;
  logic [7:0]  waddr, wdata;

  logic signed [15:0] out_left, out_right;
  logic               out_valid, busy, overrun;
  logic signed [11:0] l2, r2;
  logic               v2, busy2, ovr2;

  typedef struct {
    int l;
    int r;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;
  int   nvalid = 0;

  logic [7:0] m_gain [6];
  logic [7:0] m_ch [6];
  logic [2:0] m_ctrl;

  always #5 clk = ~clk;

  psg_stereo_mixer dut (
    .clk(clk), .rst(rst), .cen_in(cen_in), .ch_in(ch_in),
    .wr(wr), .waddr(waddr), .wdata(wdata),
    .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  psg_stereo_mixer #(.OUT_BITS(12)) dut12 (
    .clk(clk), .rst(rst), .cen_in(cen2), .ch_in(ch_in),
    .wr(wr), .waddr(waddr), .wdata(wdata),
    .out_left(l2), .out_right(r2),
    .out_valid(v2), .busy(busy2), .overrun(ovr2)
  );

  function automatic exp_t model(input int ob);
    int   al, ar, s, hi, lo;
    exp_t e;
    al = 0;
    ar = 0;
    for (int i = 0; i < 6; i++) begin
      s = int'(m_ch[i]);
      if (m_ctrl[2]) s = s - 128;
      al += s * int'(m_gain[i][3:0]);
      ar += s * int'(m_gain[i][7:4]);
    end
    if (m_ctrl[1]) begin
      al = (al + ar) >>> 1;
      ar = al;
    end
    hi = (1 << (ob - 1)) - 1;
    lo = -(1 << (ob - 1));
    if (al > hi) al = hi;
    if (al < lo) al = lo;
    if (ar > hi) ar = hi;
    if (ar < lo) ar = lo;
    if (m_ctrl[0]) begin
      al = 0;
      ar = 0;
    end
    e.l = al;
    e.r = ar;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_gain[i] = 8'h88;
    m_ctrl = 3'd0;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      nvalid++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid16 L=%0d R=%0d", out_left, out_right);
      end else begin
        e = q.pop_front();
        if (int'(out_left) !== e.l || int'(out_right) !== e.r) begin
          errors++;
          $display("FAIL sample16 got L=%0d R=%0d want L=%0d R=%0d",
                   out_left, out_right, e.l, e.r);
        end
      end
    end
    if (v2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid12 L=%0d R=%0d", l2, r2);
      end else begin
        e = q2.pop_front();
        if (int'(l2) !== e.l || int'(r2) !== e.r) begin
          errors++;
          $display("FAIL sample12 got L=%0d R=%0d want L=%0d R=%0d",
                   l2, r2, e.l, e.r);
        end
      end
    end
  endtask

  task automatic wreg(input int a, input logic [7:0] d);
    wr    = 1'b1;
    waddr = 8'(a);
    wdata = d;
    if (a < 6) m_gain[a] = d;
    if (a == 6) m_ctrl = d[2:0];
    tick();
    wr = 1'b0;
  endtask

  task automatic all_gain(input logic [7:0] d);
    for (int i = 0; i < 6; i++) wreg(i, d);
  endtask

  task automatic set_ch(input int i, input int v);
    m_ch[i] = 8'(v);
    ch_in[i*8 +: 8] = 8'(v);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 6; i++) set_ch(i, v);
  endtask

  task automatic pulse(input bit second);
    if (second) begin
      cen2 = 1'b1;
      q2.push_back(model(12));
    end else begin
      cen_in = 1'b1;
      q.push_back(model(16));
    end
    tick();
    cen_in = 1'b0;
    cen2   = 1'b0;
  endtask

  task automatic wait_valid(input bit second, output int lat, output int bc);
    lat = 0;
    bc  = (second ? busy2 : busy) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (second ? v2 : out_valid) break;
      if (second ? busy2 : busy) bc++;
    end
  endtask

  task automatic sample_chk(input bit second, input string name);
    int lat, bc;
    pulse(second);
    wait_valid(second, lat, bc);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL %s_latency got %0d want 7", name, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_left !== 16'sd0 || out_right !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out got %0d/%0d want 0/0", out_left, out_right);
    end
    checks++;
    if ({out_valid, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
               {out_valid, busy, overrun});
    end
  endtask

  task automatic test_default();
    int lat, bc;
    set_all(10);
    pulse(0);
    wait_valid(0, lat, bc);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL default_latency got %0d want 7", lat);
    end
    checks++;
    if (bc !== 7) begin
      errors++;
      $display("FAIL default_busy_clks got %0d want 7", bc);
    end
  endtask

  task automatic test_gain_shadow();
    int lat, bc;
    wreg(0, 8'h0F);
    for (int i = 1; i < 6; i++) wreg(i, 8'h00);
    set_all(0);
    set_ch(0, 200);
    pulse(0);
    wreg(0, 8'hF0);
    wait_valid(0, lat, bc);
    sample_chk(0, "shadow_next");
  endtask

  task automatic test_center();
    wreg(6, 8'h04);
    all_gain(8'h11);
    set_all(0);
    sample_chk(0, "center_zero");
    set_all(255);
    sample_chk(0, "center_full");
  endtask

  task automatic test_saturate();
    wreg(6, 8'h00);
    all_gain(8'hFF);
    set_all(255);
    sample_chk(1, "sat_pos");
    wreg(6, 8'h04);
    set_all(0);
    sample_chk(1, "sat_neg");
  endtask

  task automatic test_overrun();
    int lat, bc, n0;
    wreg(6, 8'h00);
    all_gain(8'h88);
    set_all(10);
    n0 = nvalid;
    pulse(0);
    tick();
    tick();
    cen_in = 1'b1;
    tick();
    cen_in = 1'b0;
    wait_valid(0, lat, bc);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (nvalid - n0 !== 1) begin
      errors++;
      $display("FAIL overrun_valid_count got %0d want 1", nvalid - n0);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    wreg(6, 8'h80);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0", overrun);
    end
    sample_chk(0, "after_clear");
  endtask

  task automatic test_mono_mute_rst();
    int n0;
    wreg(0, 8'h0F);
    for (int i = 1; i < 6; i++) wreg(i, 8'h00);
    set_all(0);
    set_ch(0, 201);
    wreg(6, 8'h03);
    sample_chk(0, "mute");
    wreg(6, 8'h02);
    sample_chk(0, "mono");
    n0 = nvalid;
    cen_in = 1'b1;
    tick();
    cen_in = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (nvalid !== n0) begin
      errors++;
      $display("FAIL rst_abort_valid got %0d want 0", nvalid - n0);
    end
    checks++;
    if (out_left !== 16'sd0 || out_right !== 16'sd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort_state got L=%0d R=%0d busy=%b want 0/0/0",
               out_left, out_right, busy);
    end
    set_all(10);
    sample_chk(0, "post_rst_default");
  endtask

  initial begin
    rst    = 1'b1;
    cen_in = 1'b0;
    cen2   = 1'b0;
    wr     = 1'b0;
    waddr  = 8'd0;
    wdata  = 8'd0;
    ch_in  = '0;
    for (int i = 0; i < 6; i++) m_ch[i] = 8'd0;
    test_reset();
    test_default();
    test_gain_shadow();
    test_center();
    test_saturate();
    test_overrun();
    test_mono_mute_rst();
    checks++;
    if (q.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0",
               q.size(), q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
